// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM state encoding,
// parity type constants and an id-width helper.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LAUNCH    = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } arb_state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Number of bits needed to encode values 0..value-1, never less than one.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return (result < 1) ? 1 : result;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// Combinational round-robin selector: searches ptr+1, ptr+2, ... wrapping
// modulo N_REQ and reports the first asserted request as one-hot + index.
module rr_arbiter
  import uart_pkg::*;
#(
  parameter  int N_REQ = 4,
  localparam int ID_W  = clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  grant_id,
  output logic             any_req
);

  int              cand;
  logic [ID_W-1:0] cand_id;
  logic            found;

  // Walk the candidates in priority order starting just after the last winner.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    cand     = 0;
    cand_id  = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = int'(ptr) + i;
      if (cand >= N_REQ) cand = cand - N_REQ;
      cand_id = ID_W'(cand);
      if (!found && req[cand_id]) begin
        found           = 1'b1;
        grant[cand_id]  = 1'b1;
        grant_id        = cand_id;
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between N_REQ requesters. A round-robin winner
// is captured in IDLE, launched with a one-cycle data-valid / ready pulse, and
// the frame is then tracked through the transmitter busy flag.
// Optional launch timeout: define UART_ARB_TIMEOUT_EN to abandon a launch when
// busy never rises within TIMEOUT_CYC cycles of entering WAIT_BUSY.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter  int N_REQ       = 4,
  parameter  int DATA_WIDTH  = 8,
  parameter  int TIMEOUT_CYC = 16,
  localparam int ID_W        = clog2(N_REQ)
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic [N_REQ-1:0]            i_req_valid,
  input  logic [N_REQ*DATA_WIDTH-1:0] i_req_data,
  input  logic [N_REQ-1:0]            i_req_par_type,
  input  logic [N_REQ-1:0]            i_req_par_en,
  output logic [N_REQ-1:0]            o_req_ready,
  output logic [DATA_WIDTH-1:0]       o_tx_data,
  output logic                        o_tx_data_valid,
  output logic                        o_tx_parity_type,
  output logic                        o_tx_parity_enable,
  input  logic                        i_tx_busy,
  output logic [ID_W-1:0]             o_grant_id,
  output logic                        o_active,
  output logic                        o_timeout_err
);

  arb_state_t            state_q, state_d;
  logic [ID_W-1:0]       ptr_q, ptr_d;
  logic [DATA_WIDTH-1:0] data_d;
  logic                  par_type_d, par_en_d;
  logic [ID_W-1:0]       id_d;
  logic                  valid_d;
  logic [N_REQ-1:0]      ready_d;
  logic                  active_d;

  logic [N_REQ-1:0]      win_grant;
  logic [ID_W-1:0]       win_id;
  logic                  any_req;

  logic [DATA_WIDTH-1:0] sel_data;
  logic                  sel_type, sel_en;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CNT_W = clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  err_q, err_d;
`endif

  rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_rr (
    .req      (i_req_valid),
    .ptr      (ptr_q),
    .grant    (win_grant),
    .grant_id (win_id),
    .any_req  (any_req)
  );

  // One-hot mux of the winning requester's payload and parity settings.
  always_comb begin
    sel_data = '0;
    sel_type = 1'b0;
    sel_en   = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (win_grant[k]) begin
        sel_data = i_req_data[k*DATA_WIDTH +: DATA_WIDTH];
        sel_type = i_req_par_type[k];
        sel_en   = i_req_par_en[k];
      end
    end
  end

  // Next-state and next-output decode; captured frame fields hold by default.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    data_d     = o_tx_data;
    par_type_d = o_tx_parity_type;
    par_en_d   = o_tx_parity_enable;
    id_d       = o_grant_id;
    valid_d    = 1'b0;
    ready_d    = '0;
`ifdef UART_ARB_TIMEOUT_EN
    cnt_d      = cnt_q;
    err_d      = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (any_req && !i_tx_busy) begin
          state_d    = ST_LAUNCH;
          ptr_d      = win_id;
          data_d     = sel_data;
          par_type_d = sel_type;
          par_en_d   = sel_en;
          id_d       = win_id;
          valid_d    = 1'b1;
          ready_d    = win_grant;
        end
      end
      ST_LAUNCH: begin
        state_d = ST_WAIT_BUSY;
`ifdef UART_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      ST_WAIT_BUSY: begin
        if (i_tx_busy) begin
          state_d = ST_WAIT_DONE;
        end
`ifdef UART_ARB_TIMEOUT_EN
        // Abandon the launch; the pointer keeps this winner so it counts as served.
        else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      ST_WAIT_DONE: begin
        if (!i_tx_busy) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    active_d = (state_d != ST_IDLE);
  end

  // State, pointer and registered outputs; reset returns everything to idle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q            <= ST_IDLE;
      ptr_q              <= ID_W'(N_REQ - 1);
      o_tx_data          <= '0;
      o_tx_parity_type   <= 1'b0;
      o_tx_parity_enable <= 1'b0;
      o_grant_id         <= '0;
      o_tx_data_valid    <= 1'b0;
      o_req_ready        <= '0;
      o_active           <= 1'b0;
    end else begin
      state_q            <= state_d;
      ptr_q              <= ptr_d;
      o_tx_data          <= data_d;
      o_tx_parity_type   <= par_type_d;
      o_tx_parity_enable <= par_en_d;
      o_grant_id         <= id_d;
      o_tx_data_valid    <= valid_d;
      o_req_ready        <= ready_d;
      o_active           <= active_d;
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  // Launch timeout counter and its one-cycle error pulse.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign o_timeout_err = err_q;
`else
  assign o_timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (N_REQ=4, DATA_WIDTH=8, TIMEOUT_CYC=16).
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  par_type;
  logic [3:0]  par_en;
  logic        tx_busy;
  logic [3:0]  req_ready;
  logic [7:0]  tx_data;
  logic        tx_dv;
  logic        tx_ptype;
  logic        tx_pen;
  logic [1:0]  grant_id;
  logic        active;
  logic        timeout_err;

  int total = 0;
  int bad   = 0;
  int dv_cnt  = 0;
  int rdy_cnt = 0;

  typedef struct {
    logic [3:0] req;
    logic [7:0] exp_data;
    logic       exp_type;
    logic       exp_en;
    logic [3:0] exp_ready;
    logic [1:0] exp_id;
  } vec_t;

  vec_t vecs [7];

  uart_tx_arbiter #(
    .N_REQ       (4),
    .DATA_WIDTH  (8),
    .TIMEOUT_CYC (16)
  ) dut (
    .i_clk              (clk),
    .i_rst_n            (rst_n),
    .i_req_valid        (req_valid),
    .i_req_data         (req_data),
    .i_req_par_type     (par_type),
    .i_req_par_en       (par_en),
    .o_req_ready        (req_ready),
    .o_tx_data          (tx_data),
    .o_tx_data_valid    (tx_dv),
    .o_tx_parity_type   (tx_ptype),
    .o_tx_parity_enable (tx_pen),
    .i_tx_busy          (tx_busy),
    .o_grant_id         (grant_id),
    .o_active           (active),
    .o_timeout_err      (timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want test end");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic count_pulses();
    if (tx_dv) dv_cnt++;
    if (|req_ready) rdy_cnt++;
  endtask

  task automatic wait_launch(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      count_pulses();
      if (tx_dv) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Called at the LAUNCH negedge: requester drops valid, TX goes busy for one cycle.
  task automatic finish_frame(input logic [7:0] exp_data);
    req_valid = 4'b0000;
    @(negedge clk);
    check("wait_busy_dv", 32'(tx_dv), 32'd0);
    check("wait_busy_ready", 32'(req_ready), 32'd0);
    tx_busy = 1'b1;
    @(negedge clk);
    tx_busy = 1'b0;
    @(negedge clk);
    check("back_idle_active", 32'(active), 32'd0);
    check("hold_data", 32'(tx_data), 32'(exp_data));
  endtask

  initial begin
    bit ok;
    int n;
    bit seen;

    rst_n     = 1'b0;
    req_valid = 4'b0000;
    req_data  = 32'hF03C_A511;
    par_type  = 4'b1010;
    par_en    = 4'b0110;
    tx_busy   = 1'b0;

    //           req       data   type  en    ready     id
    vecs[0] = '{4'b0010, 8'hA5, 1'b1, 1'b1, 4'b0010, 2'd1};
    vecs[1] = '{4'b1111, 8'h3C, 1'b0, 1'b1, 4'b0100, 2'd2};
    vecs[2] = '{4'b0011, 8'h11, 1'b0, 1'b0, 4'b0001, 2'd0};
    vecs[3] = '{4'b1000, 8'hF0, 1'b1, 1'b0, 4'b1000, 2'd3};
    vecs[4] = '{4'b0101, 8'h11, 1'b0, 1'b0, 4'b0001, 2'd0};
    vecs[5] = '{4'b0101, 8'h3C, 1'b0, 1'b1, 4'b0100, 2'd2};
    vecs[6] = '{4'b0001, 8'h11, 1'b0, 1'b0, 4'b0001, 2'd0};

    repeat (2) @(negedge clk);
    check("rst_active", 32'(active), 32'd0);
    check("rst_dv", 32'(tx_dv), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_data", 32'(tx_data), 32'd0);
    check("rst_id", 32'(grant_id), 32'd0);
    check("rst_par", 32'({tx_ptype, tx_pen}), 32'd0);
    check("rst_err", 32'(timeout_err), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_no_req_dv", 32'(tx_dv), 32'd0);

    // Table of single grants walking the round-robin pointer.
    for (int v = 0; v < 7; v++) begin
      req_valid = vecs[v].req;
      tx_busy   = 1'b0;
      @(negedge clk);
      check("vec_dv", 32'(tx_dv), 32'd1);
      check("vec_ready", 32'(req_ready), 32'(vecs[v].exp_ready));
      check("vec_id", 32'(grant_id), 32'(vecs[v].exp_id));
      check("vec_data", 32'(tx_data), 32'(vecs[v].exp_data));
      check("vec_ptype", 32'(tx_ptype), 32'(vecs[v].exp_type));
      check("vec_pen", 32'(tx_pen), 32'(vecs[v].exp_en));
      check("vec_active", 32'(active), 32'd1);
      finish_frame(vecs[v].exp_data);
    end

    // Request while the transmitter is still busy in IDLE.
    req_valid = 4'b0001;
    tx_busy   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("busy_hold_dv", 32'(tx_dv), 32'd0);
      check("busy_hold_active", 32'(active), 32'd0);
    end
    tx_busy = 1'b0;
    @(negedge clk);
    check("busy_release_dv", 32'(tx_dv), 32'd1);
    check("busy_release_ready", 32'(req_ready), 32'b0001);
    finish_frame(8'h11);

    // Requester 3 withdraws before it would have won (pointer sits at 2).
    req_valid = 4'b0100;
    @(negedge clk);
    check("setup_ptr2_id", 32'(grant_id), 32'd2);
    finish_frame(8'h3C);
    tx_busy   = 1'b1;
    req_valid = 4'b1001;
    repeat (2) @(negedge clk);
    check("drop_wait_dv", 32'(tx_dv), 32'd0);
    req_valid = 4'b0001;
    tx_busy   = 1'b0;
    @(negedge clk);
    check("drop_id", 32'(grant_id), 32'd0);
    check("drop_ready", 32'(req_ready), 32'b0001);
    check("drop_err", 32'(timeout_err), 32'd0);
    finish_frame(8'h11);

    // Asynchronous reset in WAIT_DONE, then requester 2 is served.
    req_valid = 4'b0001;
    @(negedge clk);
    check("mid_launch_dv", 32'(tx_dv), 32'd1);
    req_valid = 4'b0000;
    @(negedge clk);
    tx_busy = 1'b1;
    @(negedge clk);
    check("mid_wait_done_active", 32'(active), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_active", 32'(active), 32'd0);
    check("mid_rst_data", 32'(tx_data), 32'd0);
    check("mid_rst_id_par", 32'({grant_id, tx_ptype, tx_pen, tx_dv}), 32'd0);
    @(negedge clk);
    rst_n     = 1'b1;
    tx_busy   = 1'b0;
    req_valid = 4'b0100;
    @(negedge clk);
    check("post_rst_dv", 32'(tx_dv), 32'd1);
    check("post_rst_id", 32'(grant_id), 32'd2);
    check("post_rst_ready", 32'(req_ready), 32'b0100);
    check("post_rst_data", 32'(tx_data), 32'h3C);
    finish_frame(8'h3C);

    // All four requesting continuously, busy held 10 cycles per frame.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n     = 1'b1;
    req_valid = 4'b1111;
    dv_cnt    = 0;
    rdy_cnt   = 0;
    for (int f = 0; f < 5; f++) begin
      wait_launch(ok);
      check("rr_launch_seen", 32'(ok), 32'd1);
      check("rr_order_id", 32'(grant_id), 32'(f % 4));
      check("rr_order_ready", 32'(req_ready), 32'(1 << (f % 4)));
      tx_busy = 1'b1;
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        count_pulses();
      end
      tx_busy = 1'b0;
      if (f == 4) req_valid = 4'b0000;
    end
    repeat (3) begin
      @(negedge clk);
      count_pulses();
    end
    check("rr_dv_pulses", 32'(dv_cnt), 32'd5);
    check("rr_ready_pulses", 32'(rdy_cnt), 32'd5);

    // Busy never rises after a launch (pointer 0, so requester 1 wins).
    req_valid = 4'b1111;
    wait_launch(ok);
    check("to_launch_seen", 32'(ok), 32'd1);
    check("to_launch_id", 32'(grant_id), 32'd1);
`ifdef UART_ARB_TIMEOUT_EN
    n    = 0;
    seen = 1'b0;
    for (int i = 1; i <= 30 && !seen; i++) begin
      @(negedge clk);
      if (timeout_err) begin
        seen = 1'b1;
        n    = i;
      end
    end
    check("to_err_seen", 32'(seen), 32'd1);
    check("to_err_delay", 32'(n), 32'd17);
    check("to_err_idle", 32'(active), 32'd0);
    wait_launch(ok);
    check("to_next_launch", 32'(ok), 32'd1);
    check("to_next_id", 32'(grant_id), 32'd2);
    check("to_err_one_cycle", 32'(timeout_err), 32'd0);
`else
    n    = 0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tx_dv) n++;
      if (timeout_err) seen = 1'b1;
    end
    check("stuck_no_relaunch", 32'(n), 32'd0);
    check("stuck_no_err", 32'(seen), 32'd0);
    check("stuck_active", 32'(active), 32'd1);
    check("stuck_id", 32'(grant_id), 32'd1);
`endif
    req_valid = 4'b0000;
    rst_n     = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
